// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory arbiter.
//   owner_t      : which requester held the most recent grant
//   DMEM_WORDS   : number of 32-bit words in the data memory
//   DMEM_ADDR_W  : decoded byte-address bits (word index is addr[9:2])
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    localparam int DMEM_WORDS  = 256;
    localparam int DMEM_ADDR_W = 10;

endpackage

// File: rtl/dmem_addr_check.sv
// -----------------------------------------------------------------------------
// dmem_addr_check
// Combinational legality check for one requester address.
// An address is legal when it is word aligned and every bit above the decoded
// range is zero.
//   addr   in   32  byte address from the requester
//   legal  out  1   1 = aligned and inside the memory
// -----------------------------------------------------------------------------
module dmem_addr_check
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic [31:0] addr,
    output logic        legal
);

    assign legal = (addr[1:0] == 2'b00) && (addr[31:ADDR_W] == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between the CPU MEM stage and the
// debug/program-loader port. One access per cycle, combinational grant,
// registered response one cycle after the grant.
//   clk, reset                         clock, synchronous active-high reset
//   cpu_req/we/addr/wdata  in          CPU request (held until cpu_gnt)
//   cpu_gnt                out         request accepted this cycle
//   cpu_rvalid/rdata/err   out         response for the previous CPU grant
//   dbg_*                              same set for the debug port
//   mem_read/write/addr/wdata  out     memory control
//   mem_rdata              in          memory read data (combinational)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int CPU_PRIO = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,

    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    // Port index 0 = CPU, 1 = DBG.
    logic [1:0]        port_req;
    logic [1:0]        port_we;
    logic [1:0]        port_gnt;
    logic [31:0]       port_addr  [2];
    logic [DATA_W-1:0] port_wdata [2];
    logic              port_legal [2];

    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    owner_t            last_owner_reg, last_owner_next;

    logic [1:0]        rvalid_reg;
    logic [1:0]        err_reg;
    logic [DATA_W-1:0] rdata_reg [2];

    logic              dbg_wins_tie;
    logic              win_idx;

    assign port_req      = {dbg_req, cpu_req};
    assign port_we       = {dbg_we, cpu_we};
    assign port_addr[0]  = cpu_addr;
    assign port_addr[1]  = dbg_addr;
    assign port_wdata[0] = cpu_wdata;
    assign port_wdata[1] = dbg_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chk
            dmem_addr_check #(
                .ADDR_W (ADDR_W)
            ) u_chk (
                .addr  (port_addr[gi]),
                .legal (port_legal[gi])
            );
        end
    endgenerate

    // Grant: a lone requester always wins; ties resolved by the starvation
    // guard (priority mode) or by alternating owners (round-robin mode).
    always_comb begin
        port_gnt     = 2'b00;
        dbg_wins_tie = 1'b0;
        if (CPU_PRIO != 0) begin
            dbg_wins_tie = (wait_cnt_reg == MAX_WAIT_C);
        end else begin
            dbg_wins_tie = (last_owner_reg == OWN_CPU);
        end
        if (!reset) begin
            if (port_req == 2'b11) begin
                port_gnt = dbg_wins_tie ? 2'b10 : 2'b01;
            end else begin
                port_gnt = port_req;
            end
        end
    end

    assign win_idx = port_gnt[1];

    // Illegal accesses are granted but never reach the memory strobes.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (port_gnt != 2'b00) begin
            mem_addr  = port_addr[win_idx];
            mem_wdata = port_wdata[win_idx];
            mem_read  = port_legal[win_idx] & ~port_we[win_idx];
            mem_write = port_legal[win_idx] &  port_we[win_idx];
        end
    end

    always_comb begin
        wait_cnt_next   = wait_cnt_reg;
        last_owner_next = last_owner_reg;
        if (port_gnt[1]) begin
            wait_cnt_next = '0;
        end else if (dbg_req && (wait_cnt_reg != MAX_WAIT_C)) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end
        if (port_gnt[0]) begin
            last_owner_next = OWN_CPU;
        end else if (port_gnt[1]) begin
            last_owner_next = OWN_DBG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg   <= '0;
            last_owner_reg <= OWN_DBG;
            rvalid_reg     <= '0;
            err_reg        <= '0;
            for (int i = 0; i < 2; i++) begin
                rdata_reg[i] <= '0;
            end
        end else begin
            wait_cnt_reg   <= wait_cnt_next;
            last_owner_reg <= last_owner_next;
            for (int i = 0; i < 2; i++) begin
                rvalid_reg[i] <= port_gnt[i];
                err_reg[i]    <= port_gnt[i] & ~port_legal[i];
                rdata_reg[i]  <= (port_gnt[i] && port_legal[i] && !port_we[i])
                                 ? mem_rdata : '0;
            end
        end
    end

    // Responses are masked while reset is high so an in-flight response is
    // dropped immediately rather than surfacing during the reset cycle.
    assign cpu_gnt    = port_gnt[0];
    assign dbg_gnt    = port_gnt[1];
    assign cpu_rvalid = rvalid_reg[0] & ~reset;
    assign dbg_rvalid = rvalid_reg[1] & ~reset;
    assign cpu_err    = err_reg[0] & ~reset;
    assign dbg_err    = err_reg[1] & ~reset;
    assign cpu_rdata  = reset ? '0 : rdata_reg[0];
    assign dbg_rdata  = reset ? '0 : rdata_reg[1];

endmodule
